button_event_classifier: RTL and testbench

Classifies the clean level from the debounce stage into discrete button events: press, release, short press, long press and double press. It sits directly downstream of `debounce`, in the same clock domain, and drives one-cycle event strobes into the control logic. Everything is timed in clock cycles.

---
 rtl/button_event_classifier.sv | 161 ++++++++++++++++
 tb/tb_button_event_classifier.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event_classifier.sv
// button_event_classifier
//
// Turns the clean, debounced button level into one-cycle event strobes for
// the control logic: press/release edges plus short, long and double press
// classification. Everything is timed in clock cycles of clk_i.
//
// Parameters
//   LONG_CYCLES : hold length (cycles from press_pulse_o) at which
//                 long_press_o fires; must be >= 2.
//   GAP_CYCLES  : window (cycles from release_pulse_o) in which a second
//                 press makes a double press; must be >= 2.
//   CNT_WIDTH   : counter width; must hold max(LONG_CYCLES, GAP_CYCLES) - 1.
//
// Ports
//   clk_i           : clock, rising edge.
//   rst_i           : asynchronous, active-high reset.
//   in_i            : debounced level, 1 = pressed, synchronous to clk_i.
//   press_pulse_o   : one-cycle strobe per 0->1 edge of in_i.
//   release_pulse_o : one-cycle strobe per 1->0 edge of in_i.
//   short_press_o   : one-cycle strobe for a single short press.
//   long_press_o    : one-cycle strobe when a hold reaches LONG_CYCLES.
//   double_press_o  : one-cycle strobe when a second press is released.
//   busy_o          : high while a press sequence is being classified.
//
// Handshake: there is none. in_i is a plain level sampled every cycle and
// every output is a registered strobe/level with no back-pressure; a
// consumer must act on a strobe in the single cycle it is high.
module button_event_classifier #(
  parameter int unsigned LONG_CYCLES = 20,
  parameter int unsigned GAP_CYCLES  = 8,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic short_press_o,
  output logic long_press_o,
  output logic double_press_o,
  output logic busy_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESS1    = 3'd1,
    S_LONG_HOLD = 3'd2,
    S_WAIT2     = 3'd3,
    S_PRESS2    = 3'd4
  } state_e;

  localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 in_d_q;
  logic                 rise, fall;

  logic short_d, long_d, double_d, busy_d;

  // Edge detection against the previous sample. in_d_q resets to 0, so a
  // level held high through reset release is seen as a fresh press.
  assign rise = in_i & ~in_d_q;
  assign fall = ~in_i & in_d_q;

  // Next-state / strobe logic. Edge checks come before the counter checks
  // in PRESS1 and WAIT2 so that a release or re-press landing on the same
  // edge as a threshold wins over the threshold.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_PRESS1;
          cnt_d   = '0;
        end
      end

      S_PRESS1: begin
        if (fall) begin
          state_d = S_WAIT2;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = S_LONG_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // A long press is fully reported already; its release only ends it.
      S_LONG_HOLD: begin
        if (fall) begin
          state_d = S_IDLE;
        end
      end

      S_WAIT2: begin
        if (rise) begin
          state_d = S_PRESS2;
        end else if (cnt_q == GAP_LAST) begin
          short_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // Hold time of the second press is deliberately not tracked.
      S_PRESS2: begin
        if (fall) begin
          double_d = 1'b1;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // busy rises together with press_pulse (next state already non-idle) and
  // falls one cycle after the terminal strobe (current state still
  // non-idle in the cycle the strobe is shown). A back-to-back re-press in
  // IDLE keeps it high without a gap.
  assign busy_d = (state_q != S_IDLE) || (state_d != S_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      in_d_q          <= 1'b0;
      press_pulse_o   <= 1'b0;
      release_pulse_o <= 1'b0;
      short_press_o   <= 1'b0;
      long_press_o    <= 1'b0;
      double_press_o  <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      in_d_q          <= in_i;
      press_pulse_o   <= rise;
      release_pulse_o <= fall;
      short_press_o   <= short_d;
      long_press_o    <= long_d;
      double_press_o  <= double_d;
      busy_o          <= busy_d;
    end
  end

endmodule

// File: tb/tb_button_event_classifier.sv
// Directed bench for button_event_classifier with default parameters.
// Expected strobes are queued as {kind, cycle} codes when a step is driven
// and popped as the DUT shows them; expected busy levels are queued the
// same way with the cycle they apply to.
module tb_button_event_classifier;

  logic clk = 1'b0;
  logic rst;
  logic in_s;
  logic press, release_p, short_p, long_p, double_p, busy;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;
  int t;

  logic [31:0] exp_q[$];
  logic [31:0] busy_q[$];

  localparam logic [3:0] K_PRESS   = 4'd1;
  localparam logic [3:0] K_RELEASE = 4'd2;
  localparam logic [3:0] K_SHORT   = 4'd3;
  localparam logic [3:0] K_LONG    = 4'd4;
  localparam logic [3:0] K_DOUBLE  = 4'd5;

  button_event_classifier #(
    .LONG_CYCLES(20),
    .GAP_CYCLES (8),
    .CNT_WIDTH  (8)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .in_i           (in_s),
    .press_pulse_o  (press),
    .release_pulse_o(release_p),
    .short_press_o  (short_p),
    .long_press_o   (long_p),
    .double_press_o (double_p),
    .busy_o         (busy)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ev(input logic [3:0] k, input int c);
    return {k, c[27:0]};
  endfunction

  task automatic exp_ev(input logic [3:0] k, input int c);
    exp_q.push_back(ev(k, c));
  endtask

  task automatic exp_busy(input int c, input logic v);
    busy_q.push_back({v, 3'b000, c[27:0]});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // scoreboard: sample away from the active edge
  always @(negedge clk) begin : mon
    logic [4:0] s;
    s = {double_p, long_p, short_p, release_p, press};
    if (rst) begin
      chk("outs_in_reset", {26'd0, press, release_p, short_p, long_p, double_p, busy}, 32'd0);
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (s[k]) begin
          if (exp_q.size() == 0) chk("ev_unexpected", ev(4'(k + 1), cyc), 32'hFFFF_FFFF);
          else chk("event", ev(4'(k + 1), cyc), exp_q.pop_front());
        end
      end
      while (exp_q.size() != 0 && exp_q[0][27:0] <= cyc[27:0])
        chk("ev_missing", ev(4'd0, cyc), exp_q.pop_front());
      while (busy_q.size() != 0 && busy_q[0][27:0] <= cyc[27:0])
        chk("busy", {busy, 3'b000, cyc[27:0]}, busy_q.pop_front());
    end
  end

  initial begin
    // 1. reset held while in toggles
    rst  = 1'b1;
    in_s = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1 in_s = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    in_s = 1'b0;
    rst  = 1'b0;
    t = cyc;
    exp_busy(t, 1'b0); exp_busy(t + 1, 1'b0); exp_busy(t + 2, 1'b0);
    tick(3);

    // 2. short press: 5 high, then low
    t = cyc;
    exp_busy(t, 1'b0);
    exp_ev(K_PRESS, t + 1);   exp_busy(t + 1, 1'b1);
    exp_ev(K_RELEASE, t + 6);
    exp_ev(K_SHORT, t + 14);  exp_busy(t + 14, 1'b1); exp_busy(t + 15, 1'b0);
    in_s = 1'b1; tick(5);
    in_s = 1'b0; tick(12);

    // 3. long press: 30 high
    t = cyc;
    exp_ev(K_PRESS, t + 1);    exp_busy(t + 1, 1'b1);
    exp_ev(K_LONG, t + 21);
    exp_ev(K_RELEASE, t + 31); exp_busy(t + 31, 1'b1); exp_busy(t + 32, 1'b0);
    in_s = 1'b1; tick(30);
    in_s = 1'b0; tick(12);

    // 4. double press: 5 high, 3 low, 5 high
    t = cyc;
    exp_ev(K_PRESS, t + 1);
    exp_ev(K_RELEASE, t + 6);
    exp_ev(K_PRESS, t + 9);
    exp_ev(K_RELEASE, t + 14);
    exp_ev(K_DOUBLE, t + 14); exp_busy(t + 14, 1'b1); exp_busy(t + 15, 1'b0);
    in_s = 1'b1; tick(5);
    in_s = 1'b0; tick(3);
    in_s = 1'b1; tick(5);
    in_s = 1'b0; tick(12);

    // 5a. 8 idle cycles between release_pulse and press_pulse: short, then
    //     the re-press starts a fresh first press with no dead cycle
    t = cyc;
    exp_ev(K_PRESS, t + 1);
    exp_ev(K_RELEASE, t + 6);
    exp_ev(K_SHORT, t + 14);  exp_busy(t + 14, 1'b1);
    exp_ev(K_PRESS, t + 15);  exp_busy(t + 15, 1'b1);
    exp_ev(K_RELEASE, t + 20);
    exp_ev(K_SHORT, t + 28);  exp_busy(t + 28, 1'b1); exp_busy(t + 29, 1'b0);
    in_s = 1'b1; tick(5);
    in_s = 1'b0; tick(9);
    in_s = 1'b1; tick(5);
    in_s = 1'b0; tick(12);

    // 5b. 7 idle cycles: re-press lands on the gap expiry edge -> double
    t = cyc;
    exp_ev(K_PRESS, t + 1);
    exp_ev(K_RELEASE, t + 6);
    exp_ev(K_PRESS, t + 14);
    exp_ev(K_RELEASE, t + 19);
    exp_ev(K_DOUBLE, t + 19); exp_busy(t + 19, 1'b1); exp_busy(t + 20, 1'b0);
    in_s = 1'b1; tick(5);
    in_s = 1'b0; tick(8);
    in_s = 1'b1; tick(5);
    in_s = 1'b0; tick(12);

    // 5c. release sampled on the long-threshold edge -> no long, short later
    t = cyc;
    exp_ev(K_PRESS, t + 1);
    exp_ev(K_RELEASE, t + 21);
    exp_ev(K_SHORT, t + 29);  exp_busy(t + 29, 1'b1); exp_busy(t + 30, 1'b0);
    in_s = 1'b1; tick(20);
    in_s = 1'b0; tick(12);

    // 5d. one cycle longer -> long fires, release ends it
    t = cyc;
    exp_ev(K_PRESS, t + 1);
    exp_ev(K_LONG, t + 21);
    exp_ev(K_RELEASE, t + 22); exp_busy(t + 22, 1'b1); exp_busy(t + 23, 1'b0);
    in_s = 1'b1; tick(21);
    in_s = 1'b0; tick(12);

    // 6. asynchronous reset in the first press at cnt = 10, in held high
    t = cyc;
    exp_ev(K_PRESS, t + 1); exp_busy(t + 1, 1'b1);
    in_s = 1'b1; tick(11);
    chk("busy_before_rst", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1 chk("async_clear", {26'd0, press, release_p, short_p, long_p, double_p, busy}, 32'd0);
    tick(2);
    rst = 1'b0;
    t = cyc;
    exp_busy(t, 1'b0);
    exp_ev(K_PRESS, t + 1);    exp_busy(t + 1, 1'b1);
    exp_ev(K_LONG, t + 21);
    exp_ev(K_RELEASE, t + 26); exp_busy(t + 26, 1'b1); exp_busy(t + 27, 1'b0);
    tick(25);
    in_s = 1'b0; tick(6);

    chk("events_left", 32'(exp_q.size()), 32'd0);
    chk("busy_left", 32'(busy_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
